// File: rtl/apb3_master_arbiter.sv
// Two-requester APB3 master: round-robin grant, SETUP/ACCESS sequencing,
// and an ACCESS-phase timeout for slaves that never raise PREADY.
module apb3_master_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        WRITE0,
  input  logic        WRITE1,
  input  logic [31:0] ADDR0,
  input  logic [31:0] ADDR1,
  input  logic [31:0] WDATA0,
  input  logic [31:0] WDATA1,
  output logic        ACK0,
  output logic        ACK1,
  output logic [31:0] RDATA,
  output logic        ERR,
  output logic        BUSY,
  output logic [31:0] PADDR,
  output logic        PSEL,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [31:0] PWDATA,
  input  logic [31:0] PRDATA,
  input  logic        PREADY,
  input  logic        PSLVERR
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, DONE = 2'd3} state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
  localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);

  state_t      state, state_nx;
  logic        gnt, gnt_nx, last_gnt, last_gnt_nx;
  logic        pick, timeout_hit;
  logic [15:0] wait_cnt, wait_cnt_nx;
  logic [31:0] paddr_nx, pwdata_nx, rdata_nx;
  logic        pwrite_nx, err_nx, psel_nx, penable_nx, ack0_nx, ack1_nx, busy_nx;

  // On a tie the requester that was not served last wins.
  assign pick        = (REQ0 && REQ1) ? ~last_gnt : REQ1;
  assign timeout_hit = TIMEOUT_EN && (wait_cnt == TIMEOUT_VAL);

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state    <= IDLE;
      gnt      <= 1'b0;
      last_gnt <= 1'b1;
      wait_cnt <= 16'd0;
      PADDR    <= 32'd0;
      PWRITE   <= 1'b0;
      PWDATA   <= 32'd0;
      RDATA    <= 32'd0;
      ERR      <= 1'b0;
      PSEL     <= 1'b0;
      PENABLE  <= 1'b0;
      ACK0     <= 1'b0;
      ACK1     <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_nx;
      gnt      <= gnt_nx;
      last_gnt <= last_gnt_nx;
      wait_cnt <= wait_cnt_nx;
      PADDR    <= paddr_nx;
      PWRITE   <= pwrite_nx;
      PWDATA   <= pwdata_nx;
      RDATA    <= rdata_nx;
      ERR      <= err_nx;
      PSEL     <= psel_nx;
      PENABLE  <= penable_nx;
      ACK0     <= ack0_nx;
      ACK1     <= ack1_nx;
      BUSY     <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (REQ0 || REQ1) state_nx = SETUP;
      SETUP:   state_nx = ACCESS;
      ACCESS:  if (PREADY || timeout_hit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed from the next state so they register in step with it.
  always_comb begin
    gnt_nx      = gnt;
    last_gnt_nx = last_gnt;
    wait_cnt_nx = wait_cnt;
    paddr_nx    = PADDR;
    pwrite_nx   = PWRITE;
    pwdata_nx   = PWDATA;
    rdata_nx    = RDATA;
    err_nx      = ERR;
    psel_nx     = (state_nx == SETUP) || (state_nx == ACCESS);
    penable_nx  = (state_nx == ACCESS);
    busy_nx     = (state_nx != IDLE);
    ack0_nx     = (state_nx == DONE) && !gnt;
    ack1_nx     = (state_nx == DONE) && gnt;
    case (state)
      IDLE: begin
        if (state_nx == SETUP) begin
          gnt_nx      = pick;
          last_gnt_nx = pick;
          wait_cnt_nx = 16'd0;
          paddr_nx    = pick ? ADDR1  : ADDR0;
          pwrite_nx   = pick ? WRITE1 : WRITE0;
          pwdata_nx   = pick ? WDATA1 : WDATA0;
        end
      end
      ACCESS: begin
        if (PREADY) begin
          rdata_nx = PWRITE ? 32'd0 : PRDATA;
          err_nx   = PSLVERR;
        end else if (timeout_hit) begin
          rdata_nx = 32'd0;
          err_nx   = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + 16'd1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb3_master_arbiter.sv
// Directed plus randomized bench for apb3_master_arbiter, checked against a
// transaction-level model (round-robin winner, latency 3+min(waits,T)).
module tb_apb3_master_arbiter;

  localparam int T = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b1;
  logic        REQ0 = 1'b0, REQ1 = 1'b0, WRITE0 = 1'b0, WRITE1 = 1'b0;
  logic [31:0] ADDR0 = '0, ADDR1 = '0, WDATA0 = '0, WDATA1 = '0;
  logic        ACK0, ACK1, ERR, BUSY, PSEL, PENABLE, PWRITE;
  logic [31:0] RDATA, PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0, PSLVERR = 1'b0;

  apb3_master_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .REQ0(REQ0), .REQ1(REQ1), .WRITE0(WRITE0), .WRITE1(WRITE1),
    .ADDR0(ADDR0), .ADDR1(ADDR1), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .ACK0(ACK0), .ACK1(ACK1), .RDATA(RDATA), .ERR(ERR), .BUSY(BUSY),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_pass = 0, n_total = 0;
  bit last_g = 1'b1;

  // Slave model: raises PREADY after slv_wait low ACCESS cycles.
  int          slv_wait = 0;
  bit          slv_err = 1'b0;
  logic [31:0] slv_rdata = '0;
  int          acc = 0;

  always @(negedge PCLK) begin
    if (PSEL && PENABLE) begin
      if (acc == slv_wait) begin
        PREADY = 1'b1; PRDATA = slv_rdata; PSLVERR = slv_err;
      end else begin
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom_range(0, 1));
      end
      acc++;
    end else begin
      PREADY = 1'b0; PSLVERR = 1'b0; acc = 0;
    end
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic xfer(input string tag, input bit r0, input bit r1, input bit w0, input bit w1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input int w, input bit se, input logic [31:0] prd);
    bit          win, got, e_wr, e_err;
    int          lat, cyc;
    logic [31:0] e_addr, e_wd, e_rd;
    @(negedge PCLK);
    win    = (r0 && r1) ? !last_g : r1;
    last_g = win;
    e_addr = win ? a1 : a0;
    e_wd   = win ? d1 : d0;
    e_wr   = win ? w1 : w0;
    lat    = 3 + ((w < T) ? w : T);
    e_err  = (w > T) ? 1'b1 : se;
    e_rd   = (w > T || e_wr) ? 32'h0 : prd;
    slv_wait = w; slv_err = se; slv_rdata = prd;
    REQ0 = r0; REQ1 = r1; WRITE0 = w0; WRITE1 = w1;
    ADDR0 = a0; ADDR1 = a1; WDATA0 = d0; WDATA1 = d1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge PCLK);
      cyc++;
      if (cyc == 1) begin
        check1({tag, ".setup_psel"}, PSEL, 1'b1);
        check1({tag, ".setup_penable"}, PENABLE, 1'b0);
        check1({tag, ".setup_busy"}, BUSY, 1'b1);
        check32({tag, ".paddr"}, PADDR, e_addr);
        check1({tag, ".pwrite"}, PWRITE, e_wr);
        check32({tag, ".pwdata"}, PWDATA, e_wd);
      end
      if (cyc == 2) check1({tag, ".access_penable"}, PENABLE, 1'b1);
      got = ACK0 | ACK1;
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    check32({tag, ".ack_cycle"}, 32'(cyc), 32'(lat));
    check1({tag, ".ack0"}, ACK0, !win);
    check1({tag, ".ack1"}, ACK1, win);
    check32({tag, ".rdata"}, RDATA, e_rd);
    check1({tag, ".err"}, ERR, e_err);
    check1({tag, ".done_psel"}, PSEL, 1'b0);
    @(negedge PCLK);
    check1({tag, ".idle_busy"}, BUSY, 1'b0);
    check1({tag, ".idle_noack"}, ACK0 | ACK1, 1'b0);
  endtask

  initial begin
    bit          win, got, r0, r1;
    int          cyc, start, n, sel;
    logic [31:0] ca0, ca1;

    // Reset values
    repeat (2) @(negedge PCLK);
    check1("rst.psel", PSEL, 1'b0);
    check1("rst.penable", PENABLE, 1'b0);
    check1("rst.pwrite", PWRITE, 1'b0);
    check1("rst.ack0", ACK0, 1'b0);
    check1("rst.ack1", ACK1, 1'b0);
    check1("rst.err", ERR, 1'b0);
    check1("rst.busy", BUSY, 1'b0);
    check32("rst.paddr", PADDR, 32'h0);
    check32("rst.pwdata", PWDATA, 32'h0);
    check32("rst.rdata", RDATA, 32'h0);
    PRESET = 1'b0;

    xfer("single_read", 1, 0, 0, 0, 32'h4000_0010, 32'h0, 32'h0, 32'h0, 0, 0, 32'hDEAD_BEEF);
    xfer("write_3ws", 0, 1, 0, 1, 32'h0, 32'h4000_0020, 32'h0, 32'h1234_5678, 3, 0, 32'h5555_AAAA);
    xfer("slverr", 1, 0, 0, 0, 32'h4000_0030, 32'h0, 32'h0, 32'h0, 0, 1, 32'h0BAD_0BAD);
    xfer("timeout", 0, 1, 0, 0, 32'h0, 32'h4000_0040, 32'h0, 32'h0, 100, 0, 32'h1111_2222);

    // Contention: both requesters held, expect alternation every 4 cycles.
    @(negedge PCLK);
    ca0 = 32'hA000_0000; ca1 = 32'hB000_0004;
    slv_wait = 0; slv_err = 1'b0; slv_rdata = 32'hCAFE_0001;
    REQ0 = 1'b1; REQ1 = 1'b1; WRITE0 = 1'b0; WRITE1 = 1'b0; ADDR0 = ca0; ADDR1 = ca1;
    cyc = 0;
    for (int k = 0; k < 4; k++) begin
      win = !last_g; last_g = win;
      got = 1'b0; start = cyc;
      while (!got && cyc - start < 20) begin
        @(negedge PCLK);
        cyc++;
        got = ACK0 | ACK1;
      end
      check32("cont.ack_cycle", 32'(cyc), 32'(3 + 4 * k));
      check1("cont.ack0", ACK0, !win);
      check1("cont.ack1", ACK1, win);
      check32("cont.paddr", PADDR, win ? ca1 : ca0);
      check32("cont.rdata", RDATA, 32'hCAFE_0001);
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    @(negedge PCLK);
    check1("cont.idle_busy", BUSY, 1'b0);

    // Randomized transactions
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 2));
      r0 = (sel != 1); r1 = (sel != 0);
      xfer("rnd", r0, r1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom, $urandom, $urandom, $urandom,
           int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Reset while in ACCESS
    @(negedge PCLK);
    slv_wait = 100; REQ0 = 1'b1; REQ1 = 1'b0; WRITE0 = 1'b0; ADDR0 = 32'h4000_0050;
    n = 0;
    while (!PENABLE && n < 10) begin
      @(negedge PCLK);
      n++;
    end
    check1("rst_acc.reached_access", PENABLE, 1'b1);
    #1 PRESET = 1'b1;
    #1;
    check1("rst_acc.psel", PSEL, 1'b0);
    check1("rst_acc.penable", PENABLE, 1'b0);
    check1("rst_acc.busy", BUSY, 1'b0);
    check32("rst_acc.paddr", PADDR, 32'h0);
    last_g = 1'b1;
    REQ0 = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge PCLK);
      check1("rst_acc.noack", ACK0 | ACK1, 1'b0);
    end
    PRESET = 1'b0;
    xfer("post_rst_tie", 1, 1, 0, 0, 32'h4000_0060, 32'h4000_0064, 32'h0, 32'h0, 1, 0, 32'h7777_0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/apb3_master_arbiter.md
# apb3_master_arbiter

Two-requester APB3 master that shares the single master port of the fabric APB3 interconnect between two on-chip requesters: the telemetry sequencer on port 0 and the command handler on port 1. It arbitrates round-robin, runs each transfer through the APB3 SETUP/ACCESS phases and returns read data and error status to the winner. An ACCESS-phase timeout aborts any transfer to a slave that never asserts PREADY.

## Interface
- TIMEOUT_CYCLES, 255: ACCESS cycles with PREADY low before abort. Range 0..65535; 0 disables the timeout.
- PCLK  in  1  sole clock; all logic on the rising edge.
- PRESET  in  1  asynchronous, active-high reset.
- REQ0, REQ1  in  1 each  transfer request. Held with its fields until the matching ACK.
- WRITE0, WRITE1  in  1 each  1 = write, 0 = read.
- ADDR0, ADDR1  in  32 each  transfer address.
- WDATA0, WDATA1  in  32 each  write data.
- ACK0, ACK1  out  1 each  one-cycle completion pulse to the granted requester.
- RDATA  out  32  read data; valid while ACK0 or ACK1 is high.
- ERR  out  1  PSLVERR or timeout status; valid while ACK0 or ACK1 is high.
- BUSY  out  1  high in any state other than IDLE.
- PADDR  out  32  APB3 address.
- PSEL  out  1  APB3 select.
- PENABLE  out  1  APB3 enable.
- PWRITE  out  1  APB3 direction.
- PWDATA  out  32  APB3 write data.
- PRDATA  in  32  APB3 read data.
- PREADY  in  1  APB3 ready.
- PSLVERR  in  1  APB3 slave error.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- IDLE
  - Samples REQ0 and REQ1.
  - Exactly one asserted: grant it.
  - Both asserted: grant the requester not granted last. The last-grant register resets to 1, so requester 0 wins the first tie.
  - On grant: latch ADDRx, WRITEx and WDATAx into PADDR, PWRITE and PWDATA; update last-grant; go to SETUP.
- SETUP: PSEL=1, PENABLE=0; go to ACCESS unconditionally.
- ACCESS
  - PSEL=1, PENABLE=1.
  - PREADY=1: capture RDATA (PRDATA for reads, 0 for writes) and ERR=PSLVERR; go to DONE.
  - PREADY=0: increment the wait counter (16 bits, cleared on entry to SETUP).
  - Wait counter equals TIMEOUT_CYCLES and TIMEOUT_CYCLES≠0: abort; RDATA=0, ERR=1; go to DONE.
- DONE
  - PSEL=0, PENABLE=0; ACK of the granted requester =1; go to IDLE.
  - REQ is not sampled in DONE. A requester drops REQ, or presents a new transaction, on the edge where it sees ACK.
- PADDR, PWRITE and PWDATA hold their value until the next grant.
- RDATA and ERR hold until the next capture.
- Reset, including mid-transfer: state returns to IDLE and every output clears at once. Any in-flight transfer is dropped with no ACK.

## Timing
- Reset values: PSEL, PENABLE, PWRITE, ACK0, ACK1, ERR and BUSY are 0; PADDR, PWDATA and RDATA are 0; last-grant is 1.
- Zero-wait transfer, with REQ sampled high in cycle 0:
  - cycle 1 is SETUP;
  - cycle 2 is ACCESS with PREADY=1;
  - cycle 3 is ACK.
- Each PREADY-low cycle in ACCESS adds one cycle.
- Back-to-back throughput is at most one transfer per 4 cycles. A requester holding REQ continuously gets a new grant in the IDLE cycle after ACK.
- Timeout abort: ACK arrives TIMEOUT_CYCLES+2 cycles after SETUP.
- PSEL stays high from SETUP through ACCESS. PENABLE is high only in ACCESS.

## Test plan
- Single read: REQ0 with ADDR0=0x40000010, slave PREADY=1 and PRDATA=0xDEADBEEF.
  - PSEL rises in cycle 1 and PENABLE in cycle 2.
  - ACK0 in cycle 3 with RDATA=0xDEADBEEF and ERR=0.
- Write with 3 wait states: REQ1 with WRITE1=1 and WDATA1=0x12345678.
  - PWDATA=0x12345678 throughout; PREADY low for 3 ACCESS cycles.
  - ACK1 in cycle 6 with RDATA=0.
- Contention: REQ0 and REQ1 held continuously.
  - Grant order 0,1,0,1.
  - ACKs spaced 4 cycles apart; ACK0 and ACK1 never high together.
- Slave error: read returns PSLVERR=1 with PREADY=1 → ACK with ERR=1.
- Timeout: TIMEOUT_CYCLES=4, PREADY held low.
  - Abort after 4 ACCESS cycles; PSEL drops in DONE.
  - ACK with ERR=1 and RDATA=0; FSM back in IDLE.
- Reset in ACCESS: assert PRESET while PENABLE=1.
  - PSEL, PENABLE and BUSY go to 0 asynchronously; no ACK is issued.
  - After release, a tie grants requester 0.
